fetch_realigner: RTL and testbench
==================================

Name: fetch_realigner

Overview:
- Sits between instruction fetch and decode, directly upstream of the RV32C decompressor.
- Accepts word-aligned 32-bit fetch words and buffers them as halfwords.
- Delivers one instruction per handshake with its PC, whether it is a 16-bit instruction or a 32-bit instruction straddling a word boundary.
- Supplies the raw halfword the decompressor expects, plus a compressed flag; decode muxes in the decompressor output when that flag is set.

Parameters:
RESET_PC, 32'h0000_0200, PC of the first instruction after reset; bit 0 must be 0.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
nRST  in  1  asynchronous, active-low reset.
flush  in  1  redirect (branch, jump or trap) to new_pc.
new_pc  in  32  redirect target; bit 0 is ignored and treated as 0.
fetch_req  out  1  request for the word at fetch_addr.
fetch_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
fetch_valid  in  1  fetch_data holds the word at fetch_addr; completes the request.
fetch_data  in  32  returned instruction word, little-endian halfwords.
out_valid  out  1  an instruction is available.
out_ready  in  1  decode accepts the instruction.
out_inst32  out  32  uncompressed: {hw1,hw0}; compressed: {16'h0,hw0}.
out_inst16  out  16  head halfword hw0, fed to the decompressor's inst16.
out_compressed  out  1  hw0[1:0] != 2'b11.
out_pc  out  32  PC of the instruction being presented.

Behaviour:
- Storage
  - 3-slot halfword queue: hw0 is the head, count ranges 0..3.
  - Registers head_pc[31:0], fetch_addr, drop_low.
- Reset (async, nRST low)
  - count=0.
  - head_pc=RESET_PC.
  - fetch_addr={RESET_PC[31:2],2'b00}.
  - drop_low=RESET_PC[1].
  - Outputs: out_valid=0, fetch_req=1 (once nRST is deasserted), out_inst32/out_inst16 driven 0 while count=0.
- Fetch side
  - fetch_req = !flush && count<=1 (combinational); this guarantees room for 2 halfwords.
  - A request completes when fetch_req && fetch_valid.
  - On completion with drop_low=0: enqueue fetch_data[15:0] then [31:16] (count+2).
  - On completion with drop_low=1: enqueue only [31:16] (count+1), then clear drop_low.
  - fetch_addr += 4 on every completion.
  - One request outstanding at a time; fetch_addr is stable while fetch_req is high and not yet completed.
- Output side
  - out_valid = (count>=1 && out_compressed) || count>=2.
  - A transfer occurs when out_valid && out_ready.
  - It dequeues 1 halfword if compressed, 2 otherwise.
  - head_pc advances +2 or +4 accordingly.
- Latency
  - The word returned in cycle N is presentable in cycle N+1; there is no combinational path from fetch_data to the outputs.
- Simultaneous enqueue and dequeue in one cycle is legal.
  - The new count is count − deq + enq.
  - Surviving slots shift toward the head before new halfwords are appended.
- Straddling 32-bit instruction
  - With count=1 and hw0 uncompressed, out_valid=0 until the next word arrives; then hw1 is that word's low half.
- Flush (highest priority)
  - Next cycle: count=0, head_pc=new_pc, fetch_addr={new_pc[31:2],2'b00}, drop_low=new_pc[1].
  - fetch_req is low in the flush cycle.
  - A fetch_valid arriving in the flush cycle is discarded.
  - A transfer in the flush cycle is still a completed handshake, but the queue does not dequeue, because it is cleared.
- PC and address wrap-around are modulo 2^32; there is no error.
- Outputs out_inst32/out_inst16 are don't-care when out_valid=0, but must not be X after reset.

Decomposition:
- Shared package rv32c_pkg holds:
  - typedef halfword_t (logic [15:0]);
  - localparam HWQ_DEPTH=3;
  - function is_compressed(halfword_t) returning ([1:0] != 2'b11).
- The decompressor also imports rv32c_pkg.
- One natural sub-module: hw_queue, a 3-entry halfword shift queue.
  - Enqueue 0/1/2, dequeue 0/1/2, and clear.
  - Exposes hw0, hw1 and count.

Test Plan:
- Two compressed instructions in one word: reset with RESET_PC=0x200, fetch_data=0x05054505 → two out transfers.
  - First: compressed, out_inst16=0x4505, out_pc=0x200.
  - Second: out_inst16=0x0505, out_pc=0x202.
  - Next fetch_addr=0x204.
- Straddling instruction: word0=0x00934505, word1=0x450500A0 → three transfers.
  - c 0x4505 @0x200.
  - out_inst32=0x00A00093 @0x202, out_compressed=0.
  - c 0x4505 @0x206.
  - Between word0 and word1, out_valid=0 while count=1 holds 0x0093.
- Backpressure: out_ready=0 for 6 cycles with words 0x00A00093 always available → count settles at 2–3, fetch_req=0 when count≥2, outputs held stable.
  - Releasing out_ready resumes transfers with no lost or duplicated PC.
- Misaligned redirect: flush with new_pc=0x302 → next cycle fetch_addr=0x300 and out_valid=0.
  - fetch_data=0x45050001 → low half dropped, first out_pc=0x302, out_inst16=0x4505.
- Flush colliding with a fetch: flush and fetch_valid in the same cycle (fetch_data=0xFFFFFFFF) → data discarded, count=0 next cycle, next fetch_addr={new_pc[31:2],00}.
- Reset mid-stream: assert nRST low asynchronously with count=3 → out_valid=0 immediately, fetch_addr=0x200.
  - After release, first transfer is at out_pc=0x200.

Source files
------------

// File: rtl/rv32c_pkg.sv
// Types and helpers shared by the fetch realigner and the RV32C decompressor.
package rv32c_pkg;

  typedef logic [15:0] halfword_t;

  localparam int HWQ_DEPTH = 3;
  localparam int HWQ_CNT_W = $clog2(HWQ_DEPTH + 1);

  typedef logic [HWQ_CNT_W-1:0] hwq_cnt_t;

  // Any halfword whose two low bits are not 2'b11 opens a 16-bit instruction.
  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/hw_queue.sv
// Three-entry halfword shift queue: dequeue 0..2 from the head, then append 0..2
// at the tail in the same cycle; clear empties it.
module hw_queue
  import rv32c_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear_i,
  input  logic [1:0] enq_num_i,
  input  halfword_t enq_hw0_i,
  input  halfword_t enq_hw1_i,
  input  logic [1:0] deq_num_i,
  output halfword_t hw0_o,
  output halfword_t hw1_o,
  output hwq_cnt_t  count_o
);

  halfword_t slot_q [HWQ_DEPTH];
  halfword_t slot_d [HWQ_DEPTH];
  hwq_cnt_t  count_q, count_d;

  always_comb begin
    int deq;
    int enq;
    int kept;
    // NOTE: every output of this block gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    slot_d  = slot_q;
    count_d = count_q;
    deq     = int'(deq_num_i);
    enq     = int'(enq_num_i);
    kept    = int'(count_q) - deq;

    if (clear_i) begin
      count_d = '0;
    end else begin
      for (int i = 0; i < HWQ_DEPTH; i++) begin
        if (i < kept) begin
          for (int j = 0; j < HWQ_DEPTH; j++) begin
            if (j == i + deq) slot_d[i] = slot_q[j];
          end
        end else if (i == kept && enq >= 1) begin
          slot_d[i] = enq_hw0_i;
        end else if (i == kept + 1 && enq == 2) begin
          slot_d[i] = enq_hw1_i;
        end
      end
      count_d = hwq_cnt_t'(kept + enq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are reset too (not just count) so the data outputs are
      // never X after reset, even though they are only meaningful below count.
      for (int i = 0; i < HWQ_DEPTH; i++) slot_q[i] <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign hw0_o   = slot_q[0];
  assign hw1_o   = slot_q[1];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_realigner.sv
// Turns word-aligned fetch words into one 16- or 32-bit instruction per handshake,
// with its PC, ahead of the RV32C decompressor.
module fetch_realigner
  import rv32c_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst32,
  output logic [15:0] out_inst16,
  output logic        out_compressed,
  output logic [31:0] out_pc
);

  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        drop_low_q, drop_low_d;

  halfword_t   hw0, hw1;
  hwq_cnt_t    count;
  logic [1:0]  enq_num, deq_num;
  halfword_t   enq_hw0, enq_hw1;
  logic        hw0_comp, have_one, have_two;
  logic        fetch_fire, xfer;

  hw_queue u_hw_queue (
    .clk       (CLK),
    .rst_n     (nRST),
    .clear_i   (flush),
    .enq_num_i (enq_num),
    .enq_hw0_i (enq_hw0),
    .enq_hw1_i (enq_hw1),
    .deq_num_i (deq_num),
    .hw0_o     (hw0),
    .hw1_o     (hw1),
    .count_o   (count)
  );

  // Requesting only with at most one halfword queued leaves room for a full word.
  assign fetch_req  = !flush && (count <= hwq_cnt_t'(1));
  assign fetch_fire = fetch_req && fetch_valid;

  assign hw0_comp = is_compressed(hw0);
  assign have_one = count != '0;
  assign have_two = count >= hwq_cnt_t'(2);

  assign out_valid      = (have_one && hw0_comp) || have_two;
  assign out_compressed = hw0_comp;
  assign out_pc         = head_pc_q;
  assign out_inst16     = have_one ? hw0 : 16'h0000;
  assign out_inst32     = !have_one ? 32'h0 : (hw0_comp ? {16'h0000, hw0} : {hw1, hw0});
  assign fetch_addr     = fetch_addr_q;

  assign xfer = out_valid && out_ready;

  always_comb begin
    enq_num = 2'd0;
    enq_hw0 = fetch_data[15:0];
    enq_hw1 = fetch_data[31:16];
    deq_num = 2'd0;

    if (fetch_fire) begin
      // After a redirect to an odd halfword the low half of the first word is skipped.
      enq_num = drop_low_q ? 2'd1 : 2'd2;
      enq_hw0 = drop_low_q ? fetch_data[31:16] : fetch_data[15:0];
    end
    if (xfer && !flush) deq_num = hw0_comp ? 2'd1 : 2'd2;
  end

  always_comb begin
    head_pc_d    = head_pc_q;
    fetch_addr_d = fetch_addr_q;
    drop_low_d   = drop_low_q;

    if (flush) begin
      head_pc_d    = new_pc & ~32'h1;
      fetch_addr_d = new_pc & ~32'h3;
      drop_low_d   = new_pc[1];
    end else begin
      if (xfer) head_pc_d = head_pc_q + (hw0_comp ? 32'd2 : 32'd4);
      if (fetch_fire) begin
        fetch_addr_d = fetch_addr_q + 32'd4;
        drop_low_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_pc_q    <= RESET_PC;
      fetch_addr_q <= RESET_PC & ~32'h3;
      drop_low_q   <= RESET_PC[1];
    end else begin
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      drop_low_q   <= drop_low_d;
    end
  end

endmodule

// File: tb/tb_fetch_realigner.sv
// Self-checking bench for fetch_realigner: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a halfword-queue model.
module tb_fetch_realigner;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic [31:0] new_pc;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst32;
  logic [15:0] out_inst16;
  logic        out_compressed;
  logic [31:0] out_pc;

  fetch_realigner #(.RESET_PC(32'h0000_0200)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .flush          (flush),
    .new_pc         (new_pc),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst32     (out_inst32),
    .out_inst16     (out_inst16),
    .out_compressed (out_compressed),
    .out_pc         (out_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    nRST        = 1'b0;
    flush       = 1'b0;
    new_pc      = 32'h0;
    fetch_valid = 1'b0;
    fetch_data  = 32'h0;
    out_ready   = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          flush;
    logic [31:0] new_pc;
    bit          fv;
    logic [31:0] data;
    bit          rdy;
    bit          e_valid;
    bit          e_req;
    logic [31:0] e_faddr;
    logic [31:0] e_pc;
    bit          chk_data;
    bit          e_comp;
    logic [31:0] e_inst32;
    logic [15:0] e_inst16;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit rst, input bit fl, input logic [31:0] npc, input bit fv,
                      input logic [31:0] d, input bit rdy, input bit ev, input bit er,
                      input logic [31:0] efa, input logic [31:0] epc, input bit cd,
                      input bit ec, input logic [31:0] e32, input logic [15:0] e16);
    vec_t v;
    v.rst = rst; v.flush = fl; v.new_pc = npc; v.fv = fv; v.data = d; v.rdy = rdy;
    v.e_valid = ev; v.e_req = er; v.e_faddr = efa; v.e_pc = epc; v.chk_data = cd;
    v.e_comp = ec; v.e_inst32 = e32; v.e_inst16 = e16;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  logic [31:0] m_pc, m_faddr;
  logic        m_drop, m_valid, m_req, m_comp;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a & ~32'h3);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h200;
    m_faddr = 32'h200;
    m_drop  = 1'b0;
  endtask

  task automatic model_check();
    int          cnt;
    logic [15:0] h0, h1;
    logic [31:0] s32;
    cnt     = mq.size();
    m_comp  = (cnt >= 1) ? (mq[0][1:0] != 2'b11) : 1'b0;
    m_valid = (cnt >= 1 && m_comp) || cnt >= 2;
    m_req   = !flush && cnt <= 1;
    check("rnd valid", 32'(out_valid), 32'(m_valid));
    check("rnd req", 32'(fetch_req), 32'(m_req));
    check("rnd faddr", fetch_addr, m_faddr);
    check("rnd pc", out_pc, m_pc);
    if (cnt == 0) check("rnd idle inst32", out_inst32, 32'h0);
    if (m_valid) begin
      check("rnd comp", 32'(out_compressed), 32'(m_comp));
      check("rnd inst16", 32'(out_inst16), 32'(mq[0]));
      check("rnd inst32", out_inst32, m_comp ? {16'h0, mq[0]} : {mq[1], mq[0]});
      if (out_ready) begin
        // Independent view: the instruction must be what memory holds at that PC.
        h0  = mem_hw(m_pc);
        h1  = mem_hw(m_pc + 32'd2);
        s32 = (h0[1:0] != 2'b11) ? {16'h0, h0} : {h1, h0};
        check("rnd stream", out_inst32, s32);
      end
    end
  endtask

  task automatic model_step();
    if (flush) begin
      mq.delete();
      m_pc    = new_pc & ~32'h1;
      m_faddr = new_pc & ~32'h3;
      m_drop  = new_pc[1];
    end else begin
      if (m_valid && out_ready) begin
        void'(mq.pop_front());
        if (!m_comp) void'(mq.pop_front());
        m_pc = m_pc + (m_comp ? 32'd2 : 32'd4);
      end
      if (m_req && fetch_valid) begin
        if (!m_drop) mq.push_back(fetch_data[15:0]);
        mq.push_back(fetch_data[31:16]);
        m_drop  = 1'b0;
        m_faddr = m_faddr + 32'd4;
      end
    end
  endtask

  initial begin
    int          got;
    logic [31:0] exp_pc;

    do_reset();

    // Two compressed in one word.
    addv(1,0,0,        1,32'h05054505,1, 0,1,32'h200,32'h200, 1,0,32'h0,16'h0);
    addv(0,0,0,        0,32'h0,1,        1,0,32'h204,32'h200, 1,1,32'h4505,16'h4505);
    addv(0,0,0,        0,32'h0,1,        1,1,32'h204,32'h202, 1,1,32'h0505,16'h0505);
    addv(0,0,0,        0,32'h0,0,        0,1,32'h204,32'h204, 1,0,32'h0,16'h0);
    // Straddling 32-bit instruction.
    addv(1,0,0,        1,32'h00934505,1, 0,1,32'h200,32'h200, 1,0,32'h0,16'h0);
    addv(0,0,0,        0,32'h0,1,        1,0,32'h204,32'h200, 1,1,32'h4505,16'h4505);
    addv(0,0,0,        0,32'h0,1,        0,1,32'h204,32'h202, 0,0,32'h0,16'h0);
    addv(0,0,0,        1,32'h450500A0,1, 0,1,32'h204,32'h202, 0,0,32'h0,16'h0);
    addv(0,0,0,        0,32'h0,1,        1,0,32'h208,32'h202, 1,0,32'h00A00093,16'h0093);
    addv(0,0,0,        0,32'h0,1,        1,1,32'h208,32'h206, 1,1,32'h4505,16'h4505);
    addv(0,0,0,        0,32'h0,0,        0,1,32'h208,32'h208, 1,0,32'h0,16'h0);
    // Misaligned redirect.
    addv(0,1,32'h302,  0,32'h0,0,        0,0,32'h208,32'h208, 1,0,32'h0,16'h0);
    addv(0,0,0,        1,32'h45050001,0, 0,1,32'h300,32'h302, 1,0,32'h0,16'h0);
    addv(0,0,0,        0,32'h0,1,        1,1,32'h304,32'h302, 1,1,32'h4505,16'h4505);
    // Flush colliding with a returning fetch.
    addv(0,1,32'h1000, 1,32'hFFFFFFFF,0, 0,0,32'h304,32'h304, 1,0,32'h0,16'h0);
    addv(0,0,0,        0,32'h0,0,        0,1,32'h1000,32'h1000, 1,0,32'h0,16'h0);
    // Flush during an accepted transfer: no dequeue, queue cleared.
    addv(0,0,0,        1,32'h00A00093,0, 0,1,32'h1000,32'h1000, 1,0,32'h0,16'h0);
    addv(0,1,32'h2006, 0,32'h0,1,        1,0,32'h1004,32'h1000, 1,0,32'h00A00093,16'h0093);
    addv(0,0,0,        0,32'h0,0,        0,1,32'h2004,32'h2006, 1,0,32'h0,16'h0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      @(negedge CLK);
      flush = tbl[k].flush; new_pc = tbl[k].new_pc; fetch_valid = tbl[k].fv;
      fetch_data = tbl[k].data; out_ready = tbl[k].rdy;
      #1;
      check($sformatf("vec%0d valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
      check($sformatf("vec%0d req", k), 32'(fetch_req), 32'(tbl[k].e_req));
      check($sformatf("vec%0d faddr", k), fetch_addr, tbl[k].e_faddr);
      check($sformatf("vec%0d pc", k), out_pc, tbl[k].e_pc);
      if (tbl[k].chk_data) begin
        check($sformatf("vec%0d inst32", k), out_inst32, tbl[k].e_inst32);
        check($sformatf("vec%0d inst16", k), 32'(out_inst16), 32'(tbl[k].e_inst16));
        if (tbl[k].e_valid) check($sformatf("vec%0d comp", k), 32'(out_compressed), 32'(tbl[k].e_comp));
      end
    end

    // Backpressure: decode stalls while fetch data is always available.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      fetch_valid = 1'b1; fetch_data = 32'h00A00093; out_ready = 1'b0; flush = 1'b0;
      #1;
      if (c == 0) begin
        check("bp first req", 32'(fetch_req), 32'd1);
        check("bp first valid", 32'(out_valid), 32'd0);
      end else begin
        check("bp held req", 32'(fetch_req), 32'd0);
        check("bp held valid", 32'(out_valid), 32'd1);
        check("bp held pc", out_pc, 32'h200);
        check("bp held inst", out_inst32, 32'h00A00093);
      end
    end
    got = 0;
    exp_pc = 32'h200;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge CLK);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        check("bp resume pc", out_pc, exp_pc);
        check("bp resume inst", out_inst32, 32'h00A00093);
        exp_pc += 32'd4;
        got++;
      end
    end
    if (got < 8) check("bp resume timeout", 32'(got), 32'd8);

    // Asynchronous reset with a full queue.
    do_reset();
    @(negedge CLK); fetch_valid = 1'b1; fetch_data = 32'h00934505; out_ready = 1'b0;
    @(negedge CLK); fetch_valid = 1'b0; out_ready = 1'b1;
    @(negedge CLK); fetch_valid = 1'b1; fetch_data = 32'h450500A0; out_ready = 1'b0;
    @(negedge CLK); fetch_valid = 1'b0;
    #1;
    check("rst3 pre valid", 32'(out_valid), 32'd1);
    check("rst3 pre pc", out_pc, 32'h202);
    check("rst3 pre inst", out_inst32, 32'h00A00093);
    #1 nRST = 1'b0;
    #1;
    check("rst3 valid", 32'(out_valid), 32'd0);
    check("rst3 faddr", fetch_addr, 32'h200);
    check("rst3 pc", out_pc, 32'h200);
    check("rst3 inst32", out_inst32, 32'h0);
    @(negedge CLK); nRST = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge CLK);
      fetch_valid = 1'b1; fetch_data = 32'h00934505; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        check("rst3 after pc", out_pc, 32'h200);
        check("rst3 after inst16", 32'(out_inst16), 32'h4505);
        got = 1;
      end
    end
    if (got == 0) check("rst3 after timeout", 32'(got), 32'd1);

    // Randomized run against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      flush = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) new_pc = 32'hFFFF_FFF8 | ($urandom & 32'h6);
      else new_pc = $urandom_range(0, 1023) & ~32'h1;
      fetch_valid = ($urandom_range(0, 9) < 6);
      fetch_data  = mem_word(m_faddr);
      out_ready   = ($urandom_range(0, 9) < 7);
      #1;
      model_check();
      @(posedge CLK);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
